// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter with asynchronous active-low clear.
// Periods other than 2^WIDTH are built outside by pulsing reset at the terminal value.
module counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Carry out of the MSB is dropped, so the count wraps to 0 after all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= '0;
    else        r_count <= r_count + WIDTH'(1);
  end

  assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Checks counter reset, increment, wrap and asynchronous clear, and runs a
// wrapped line-counter loop against a scoreboard of expected values.
module tb_counter;
  localparam int WIDTH = 10;

  typedef struct {
    logic             pre_reset;
    int               edges;
    logic [WIDTH-1:0] exp;
  } vec_t;

  logic             clk;
  logic             rst_tb;
  logic             lr;
  logic             line_mode;
  logic             reset;
  logic [WIDTH-1:0] count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb[$];

  assign reset = line_mode ? lr : rst_tb;

  counter #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .count(count));

  // Line-counter wrapper: pull reset low for one clk cycle once count hits 800.
  always @(negedge clk) lr <= (count != WIDTH'(800));

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: count=%0d expected=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    clk = 1'b1; #5;
    clk = 1'b0; #5;
  endtask

  task automatic pulse_reset();
    rst_tb = 1'b0; #1;
    rst_tb = 1'b1; #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 800,  WIDTH'(800)};
    vecs[1] = '{1'b0, 1,    WIDTH'(801)};
    vecs[2] = '{1'b1, 1023, WIDTH'(1023)};
    vecs[3] = '{1'b0, 1,    WIDTH'(0)};
    vecs[4] = '{1'b0, 1,    WIDTH'(1)};
    vecs[5] = '{1'b1, 500,  WIDTH'(500)};
    vecs[6] = '{1'b0, 523,  WIDTH'(1023)};
    vecs[7] = '{1'b0, 2,    WIDTH'(1)};

    clk = 1'b0; rst_tb = 1'b0; lr = 1'b1; line_mode = 1'b0;
    #3;
    check("reset_async", count, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold%0d", i), count, '0);
    end
    rst_tb = 1'b1; #1;
    check("reset_release", count, '0);
    tick();
    check("first_edge", count, WIDTH'(1));

    foreach (vecs[k]) begin
      if (vecs[k].pre_reset) pulse_reset();
      sb.push_back(vecs[k].exp);
      for (int e = 0; e < vecs[k].edges; e++) tick();
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL vec%0d: scoreboard empty", k);
      end else begin
        logic [WIDTH-1:0] req;
        req = sb.pop_front();
        check($sformatf("vec%0d", k), count, req);
      end
    end

    // Mid-count clear between edges at 500.
    pulse_reset();
    for (int e = 0; e < 500; e++) tick();
    check("pre_mid_clear", count, WIDTH'(500));
    #2 rst_tb = 1'b0; #1;
    check("mid_clear_async", count, '0);
    rst_tb = 1'b1; #1;
    check("mid_clear_release", count, '0);
    tick();
    check("mid_clear_restart", count, WIDTH'(1));

    // Reset falls in the same timestep as a rising clk edge at count 10.
    pulse_reset();
    for (int e = 0; e < 10; e++) tick();
    check("pre_coincident", count, WIDTH'(10));
    rst_tb = 1'b0;
    clk    = 1'b1; #1;
    check("coincident_edge", count, '0);
    #4 clk = 1'b0; #5;
    tick();
    check("coincident_hold", count, '0);
    rst_tb = 1'b1; #1;
    tick();
    check("coincident_restart", count, WIDTH'(1));

    // Line counter: values must run 0..800 and come back to 0, never above 800.
    pulse_reset();
    lr = 1'b1;
    line_mode = 1'b1; #1;
    begin
      int maxv, wraps, above;
      logic [WIDTH-1:0] prev;
      maxv = 0; wraps = 0; above = 0; prev = count;
      for (int e = 0; e < 1700; e++) begin
        clk = 1'b1; #2;
        if (int'(count) > maxv) maxv = int'(count);
        if (int'(count) > 800) above++;
        if (prev == WIDTH'(800) && count == '0) wraps++;
        prev = count;
        #3 clk = 1'b0; #1;
        if (prev == WIDTH'(800) && count == '0) wraps++;
        prev = count;
        #4;
      end
      check("line_max", WIDTH'(maxv), WIDTH'(800));
      check("line_above", WIDTH'(above), '0);
      check("line_wraps", WIDTH'(wraps), WIDTH'(2));
    end
    line_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
